nes_controller_reader: RTL

Upstream input stage for the game CPU. Polls a standard NES gamepad over its three-wire serial interface (latch, pulse, data) at a fixed frame rate. Deserialises the 8 button bits and presents a debounced-by-sampling, active-high 5-bit button vector that drives the CPU's `controller_in` port (consumed by `game_Inputs`). Also exposes all 8 raw buttons and a one-cycle update strobe.

---
 rtl/nes_controller_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/nes_controller_reader.sv
// NES gamepad poller: latches the pad once per POLL_PERIOD, shifts in 8 active-low
// button bits over latch/pulse/data and publishes them active-high with a valid strobe.
module nes_controller_reader #(
    parameter int DIV         = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic [4:0] controller_out,
    output logic       valid
);

    localparam int PW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int PHW = $clog2(2 * DIV);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t         state, state_n;
    logic [PW-1:0]  poll_cnt;
    logic [PHW-1:0] phase, phase_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     shreg, shreg_n;
    logic [1:0]     sync_q;
    logic           data_s;
    logic           tick;
    logic           load;

    assign data_s = sync_q[1];
    assign tick   = (poll_cnt == PW'(POLL_PERIOD - 1));

    // Synchronizer idles at 1, the pad's "nothing pressed" level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], nes_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     poll_cnt <= '0;
        else if (tick) poll_cnt <= '0;
        else           poll_cnt <= poll_cnt + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        shreg_n = shreg;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = LATCH;
                    phase_n = '0;
                    idx_n   = '0;
                end
            end
            LATCH: begin
                if (phase == PHW'(2 * DIV - 1)) begin
                    state_n = LOW;
                    phase_n = '0;
                end else begin
                    phase_n = phase + PHW'(1);
                end
            end
            LOW: begin
                if (phase == PHW'(DIV - 1)) begin
                    shreg_n[3'd7 - idx] = ~data_s;
                    phase_n = '0;
                    if (idx == 3'd7) begin
                        state_n = DONE;
                        load    = 1'b1;
                    end else begin
                        state_n = HIGH;
                    end
                end else begin
                    phase_n = phase + PHW'(1);
                end
            end
            HIGH: begin
                if (phase == PHW'(DIV - 1)) begin
                    state_n = LOW;
                    phase_n = '0;
                    idx_n   = idx + 3'd1;
                end else begin
                    phase_n = phase + PHW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered off the next state so they line up with the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nes_latch      <= 1'b0;
            nes_pulse      <= 1'b0;
            valid          <= 1'b0;
            buttons        <= '0;
            controller_out <= '0;
        end else begin
            nes_latch <= (state_n == LATCH);
            nes_pulse <= (state_n == HIGH);
            valid     <= load;
            if (load) begin
                buttons        <= shreg_n;
                controller_out <= {shreg_n[7], shreg_n[3], shreg_n[2], shreg_n[1], shreg_n[0]};
            end
        end
    end

endmodule
